// File: rtl/gearbox_pkg.sv
// Shared width constants and helpers for the transmit and receive gearboxes.
package gearbox_pkg;

    localparam int GT_WORD_W   = 16;
    localparam int PCS_BLOCK_W = 20;

    // Bits needed to count 0..in_w+out_w-1 buffered bits.
    function automatic int fill_width(input int in_w, input int out_w);
        return $clog2(in_w + out_w);
    endfunction

endpackage

// File: rtl/rx_gearbox.sv
// Receive gearbox: packs narrow transceiver words into wide PCS blocks,
// with single-bit slip for block-lock alignment search.
module rx_gearbox
    import gearbox_pkg::*;
#(
    parameter int INPUT_WIDTH  = GT_WORD_W,
    parameter int OUTPUT_WIDTH = PCS_BLOCK_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_init_done,
    input  logic [INPUT_WIDTH-1:0]  i_data,
    input  logic                    i_slip,
    output logic [OUTPUT_WIDTH-1:0] o_data,
    output logic                    o_valid
);

    localparam int BUF_W  = INPUT_WIDTH + OUTPUT_WIDTH - 1;
    localparam int FILL_W = fill_width(INPUT_WIDTH, OUTPUT_WIDTH);

    localparam logic [FILL_W-1:0] IN_STEP  = FILL_W'(INPUT_WIDTH);
    localparam logic [FILL_W-1:0] OUT_STEP = FILL_W'(OUTPUT_WIDTH);
    localparam logic [FILL_W-1:0] ONE      = FILL_W'(1);

    if (INPUT_WIDTH < 1 || INPUT_WIDTH > OUTPUT_WIDTH) begin : g_bad_width
        $error("rx_gearbox: need 1 <= INPUT_WIDTH <= OUTPUT_WIDTH");
    end

    logic [BUF_W-1:0]  buf_q;
    logic [FILL_W-1:0] fill_q;
    logic [BUF_W-1:0]  comb;
    logic [FILL_W-1:0] fill_c;
    logic              emit;

    // Bits above fill_q are always zero, so new bits can simply be OR-ed in.
    always_comb begin
        // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
        comb   = buf_q | (BUF_W'(i_data) << fill_q);
        fill_c = fill_q + IN_STEP;
        if (i_slip) begin
            comb   = comb >> 1;
            fill_c = fill_c - ONE;
        end
        emit = (fill_c >= OUT_STEP);
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else if (!i_init_done) begin
            o_valid <= 1'b0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else if (emit) begin
            o_data  <= comb[OUTPUT_WIDTH-1:0];
            o_valid <= 1'b1;
            buf_q   <= comb >> OUTPUT_WIDTH;
            fill_q  <= fill_c - OUT_STEP;
        end else begin
            o_valid <= 1'b0;
            buf_q   <= comb;
            fill_q  <= fill_c;
        end
    end

endmodule

// File: tb/tb_rx_gearbox.sv
// Self-checking bench for rx_gearbox: directed tables, slip/init/reset sequences,
// and randomized traffic against a bit-queue reference model.
module tb_rx_gearbox;

    localparam int IW = 16;
    localparam int OW = 20;

    logic          clk;
    logic          rst_n;
    logic          init_done;
    logic [IW-1:0] data;
    logic          slip;
    logic [OW-1:0] o_data;
    logic          o_valid;

    int n_checks = 0;
    int n_fail   = 0;

    rx_gearbox #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_init_done(init_done),
        .i_data     (data),
        .i_slip     (slip),
        .o_data     (o_data),
        .o_valid    (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the wire as a FIFO of bits, oldest at the front.
    bit          mq[$];
    logic [OW-1:0] m_data;
    logic          m_valid;

    function automatic void model_reset();
        mq.delete();
        m_data  = '0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic en, input logic sl, input logic [IW-1:0] d);
        if (!en) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            for (int i = 0; i < IW; i++) mq.push_back(d[i]);
            if (sl) void'(mq.pop_front());
            if (mq.size() >= OW) begin
                for (int i = 0; i < OW; i++) m_data[i] = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, advance the model, and land #1 after the edge.
    task automatic cycle(input logic en, input logic sl, input logic [IW-1:0] d);
        init_done = en;
        slip      = sl;
        data      = d;
        model_step(en, sl, d);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
        check({tag, "_data"}, 32'(o_data), 32'(m_data));
    endtask

    typedef struct {
        logic [IW-1:0] d;
        logic          exp_valid;
        logic [OW-1:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    task automatic run_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, tbl[i].d);
            check($sformatf("%s_v%0d", tag, i), 32'(o_valid), 32'(tbl[i].exp_valid));
            check($sformatf("%s_d%0d", tag, i), 32'(o_data), 32'(tbl[i].exp_data));
        end
    endtask

    initial begin
        int cnt;

        tbl[0] = '{16'd0, 1'b0, 20'h00000};
        tbl[1] = '{16'd1, 1'b1, 20'h10000};
        tbl[2] = '{16'd2, 1'b1, 20'h02000};
        tbl[3] = '{16'd3, 1'b1, 20'h00300};
        tbl[4] = '{16'd4, 1'b1, 20'h00040};
        tbl[5] = '{16'd5, 1'b0, 20'h00040};

        rst_n     = 1'b0;
        init_done = 1'b0;
        slip      = 1'b0;
        data      = '0;
        model_reset();
        #12;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_data", 32'(o_data), 32'd0);
        rst_n = 1'b1;

        // Test 1: counting words straight after reset
        run_table("t1");

        // Test 2: constant 0xAAAA from an empty buffer
        cycle(1'b0, 1'b0, '0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 16'hAAAA);
            if (o_valid) begin
                cnt++;
                check("t2_data", 32'(o_data), 32'h000AAAAA);
            end
        end
        check("t2_valid_count", 32'(cnt), 32'd80);

        // Test 3: single slip pulse flips the alignment
        cycle(1'b0, 1'b0, '0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (i == 10), 16'hAAAA);
            cmp_model("t3");
            if (i >= 10 && i < 30 && o_valid) cnt++;
            if (o_valid) check("t3_data", 32'(o_data), (i >= 10) ? 32'h00055555 : 32'h000AAAAA);
        end
        check("t3_valid_count", 32'(cnt), 32'd15);

        // Test 4: slip held 20 cycles drops 20 bits and restores alignment
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, (i >= 10 && i < 30), 16'hAAAA);
            cmp_model("t4");
            check("t4_known", 32'($isunknown({o_data, o_valid})), 32'd0);
            if (i >= 30 && o_valid) check("t4_data", 32'(o_data), 32'h000AAAAA);
        end

        // Test 5: init_done low mid-stream flushes stale bits
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'($urandom));
        cycle(1'b0, 1'b0, 16'hFFFF);
        check("t5_valid_drop", 32'(o_valid), 32'd0);
        cycle(1'b0, 1'b1, 16'hFFFF);
        cycle(1'b0, 1'b1, 16'hFFFF);
        cycle(1'b1, 1'b0, 16'h1234);
        check("t5_first_valid", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b0, 16'h5678);
        check("t5_block_valid", 32'(o_valid), 32'd1);
        check("t5_block_data", 32'(o_data), 32'h00081234);

        // Test 6: asynchronous reset mid-block, then replay test 1
        cycle(1'b1, 1'b0, 16'hBEEF);
        cycle(1'b1, 1'b0, 16'hCAFE);
        cycle(1'b1, 1'b0, 16'h0F0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(o_valid), 32'd0);
        check("t6_async_data", 32'(o_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_table("t6");

        // Randomized traffic against the bit-queue model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0), 16'($urandom));
            cmp_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
